// File: rtl/reg_file_pkg.sv
// Shared types and parameter-check helpers for the parametrised register file.
package reg_file_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit aw_ok(input int depth, input int aw);
    return aw == $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Decode/write-back side bundle of the register file: write port, two read
// ports, pending-write scoreboard and clear request.
interface reg_file_param_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          Wen;
  logic [AW-1:0] Waddr;
  logic [DW-1:0] Wdat;
  logic [AW-1:0] RaddrA;
  logic [AW-1:0] RaddrB;
  logic [DW-1:0] RdatA;
  logic [DW-1:0] RdatB;
  logic          Pend_set;
  logic [AW-1:0] Pend_addr;
  logic          PendA;
  logic          PendB;
  logic          Clr_req;
  logic          Busy;

  modport master (
    output Wen, Waddr, Wdat, RaddrA, RaddrB, Pend_set, Pend_addr, Clr_req,
    input  RdatA, RdatB, PendA, PendB, Busy
  );

  modport slave (
    input  Wen, Waddr, Wdat, RaddrA, RaddrB, Pend_set, Pend_addr, Clr_req,
    output RdatA, RdatB, PendA, PendB, Busy
  );
endinterface

// File: rtl/reg_file_clr_fsm.sv
// Clear sequencer: walks a pointer over every entry once per accepted request,
// holding busy for exactly DEPTH cycles.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_idx_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every output of this block gets a default first; a missing branch
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req_i) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        // Pointer wraps to zero naturally since DEPTH is a power of two.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = CLR_IDLE;
        end
      end
      default: begin
        state_d = CLR_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy_o    = (state_q == CLR_RUN);
  assign clr_idx_o = ptr_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with optional write bypass,
// optional zero register, pending-write scoreboard and sequenced clear.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  reg_file_param_if.slave   bus
);

  if (!depth_ok(DEPTH) || !aw_ok(DEPTH, AW)) begin : g_bad_params
    $error("reg_file_param: DEPTH must be a power of 2 >= 2 and AW = clog2(DEPTH)");
  end

  logic [DW-1:0]    core_q [DEPTH];
  logic [DW-1:0]    core_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic          busy;
  logic [AW-1:0] clr_idx;
  logic          wr_acc;
  logic          pend_acc;
  logic [DW-1:0] rdat_a, rdat_b;

  reg_file_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clr_req_i (bus.Clr_req),
    .busy_o    (busy),
    .clr_idx_o (clr_idx)
  );

  // Write-back and pending issue are dropped while the clear engine runs, and
  // anything aimed at the hard-wired zero entry is dropped as well.
  assign wr_acc   = bus.Wen && !busy && !(ZERO_REG && (bus.Waddr == '0));
  assign pend_acc = bus.Pend_set && !busy && !(ZERO_REG && (bus.Pend_addr == '0));

  always_comb begin
    core_d = core_q;
    pend_d = pend_q;
    if (busy) begin
      core_d[clr_idx] = '0;
      pend_d[clr_idx] = 1'b0;
    end
    if (wr_acc) begin
      core_d[bus.Waddr] = bus.Wdat;
      pend_d[bus.Waddr] = 1'b0;
    end
    // A same-cycle issue to the entry being written back wins: new load in flight.
    if (pend_acc) begin
      pend_d[bus.Pend_addr] = 1'b1;
    end
  end

  // NOTE: this array is built from flops, not a RAM macro, so resetting every
  // entry is legal and is what lets reset abort a clear half-way through.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      core_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      core_q <= core_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdat_a = core_q[bus.RaddrA];
    if (BYPASS && wr_acc && (bus.Waddr == bus.RaddrA)) begin
      rdat_a = bus.Wdat;
    end
    if (ZERO_REG && (bus.RaddrA == '0)) begin
      rdat_a = '0;
    end
  end

  always_comb begin
    rdat_b = core_q[bus.RaddrB];
    if (BYPASS && wr_acc && (bus.Waddr == bus.RaddrB)) begin
      rdat_b = bus.Wdat;
    end
    if (ZERO_REG && (bus.RaddrB == '0)) begin
      rdat_b = '0;
    end
  end

  assign bus.RdatA = rdat_a;
  assign bus.RdatB = rdat_b;
  assign bus.PendA = pend_q[bus.RaddrA] && !(ZERO_REG && (bus.RaddrA == '0));
  assign bus.PendB = pend_q[bus.RaddrB] && !(ZERO_REG && (bus.RaddrB == '0));
  assign bus.Busy  = busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: one instance with bypass and no zero
// register, one without bypass and with a zero register, driven in lockstep.
module tb_reg_file_param;

  logic Clk = 1'b0;
  logic Reset_n;

  always #5 Clk = ~Clk;

  reg_file_param_if #(.DW(8), .AW(3)) ifa ();
  reg_file_param_if #(.DW(8), .AW(3)) ifb ();

  reg_file_param #(
    .DW(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)
  ) dut_a (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifa)
  );

  reg_file_param #(
    .DW(8), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b1)
  ) dut_b (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifb)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       wen;
    logic [2:0] waddr;
    logic [7:0] wdat;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       pset;
    logic [2:0] paddr;
    logic [7:0] a_ra;
    logic [7:0] a_rb;
    logic       a_pa;
    logic [7:0] b_ra;
    logic [7:0] b_rb;
    logic       b_pa;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wen, input logic [2:0] waddr, input logic [7:0] wdat,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic pset, input logic [2:0] paddr, input logic clr);
    ifa.Wen = wen;  ifa.Waddr = waddr;  ifa.Wdat = wdat;
    ifa.RaddrA = ra; ifa.RaddrB = rb;
    ifa.Pend_set = pset; ifa.Pend_addr = paddr; ifa.Clr_req = clr;
    ifb.Wen = wen;  ifb.Waddr = waddr;  ifb.Wdat = wdat;
    ifb.RaddrA = ra; ifb.RaddrB = rb;
    ifb.Pend_set = pset; ifb.Pend_addr = paddr; ifb.Clr_req = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_read(input logic [2:0] ra, input logic [2:0] rb);
    drive(1'b0, 3'd0, 8'h00, ra, rb, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 3'd5, 8'h3C, 3'd3, 3'd5, 1'b0, 3'd0, 8'hA5, 8'h3C, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 1'b0, 3'd0, 8'h3C, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0, 3'd0, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 1'b1, 3'd0, 8'hFF, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 3'd2, 8'h77, 3'd2, 3'd2, 1'b0, 3'd0, 8'h77, 8'h77, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b0, 3'd0, 8'h77, 8'hFF, 1'b0, 8'h77, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 8'h99, 3'd2, 3'd3, 1'b1, 3'd2, 8'h99, 8'hA5, 1'b0, 8'h77, 8'hA5, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b0, 3'd0, 8'h99, 8'h99, 1'b1, 8'h99, 8'h99, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 1'b0, 3'd0, 8'hFF, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b0};

    // Reset held two cycles with a write pending; reset must win.
    Reset_n = 1'b0;
    drive(1'b1, 3'd3, 8'hEE, 3'd3, 3'd4, 1'b1, 3'd3, 1'b0);
    tick();
    tick();
    Reset_n = 1'b1;
    idle_read(3'd3, 3'd4);
    @(negedge Clk);
    check("rst_busy_a", 32'(ifa.Busy), 32'h0);
    check("rst_busy_b", 32'(ifb.Busy), 32'h0);
    check("rst_rdat_a3", 32'(ifa.RdatA), 32'h0);
    check("rst_pend_a3", 32'(ifa.PendA), 32'h0);
    check("rst_rdat_b4", 32'(ifb.RdatB), 32'h0);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdat, vecs[i].ra, vecs[i].rb,
            vecs[i].pset, vecs[i].paddr, 1'b0);
      @(negedge Clk);
      check($sformatf("v%0d_a_rdatA", i), 32'(ifa.RdatA), 32'(vecs[i].a_ra));
      check($sformatf("v%0d_a_rdatB", i), 32'(ifa.RdatB), 32'(vecs[i].a_rb));
      check($sformatf("v%0d_a_pendA", i), 32'(ifa.PendA), 32'(vecs[i].a_pa));
      check($sformatf("v%0d_b_rdatA", i), 32'(ifb.RdatA), 32'(vecs[i].b_ra));
      check($sformatf("v%0d_b_rdatB", i), 32'(ifb.RdatB), 32'(vecs[i].b_rb));
      check($sformatf("v%0d_b_pendA", i), 32'(ifb.PendA), 32'(vecs[i].b_pa));
      tick();
    end

    // Fill 0x11..0x88, then mark entry 4 pending.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'((i + 1) * 17), 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0);
    tick();
    idle_read(3'd7, 3'd4);
    @(negedge Clk);
    check("fill_a_r7", 32'(ifa.RdatA), 32'h88);
    check("fill_pendB4_a", 32'(ifa.PendB), 32'h1);
    check("fill_pendB4_b", 32'(ifb.PendB), 32'h1);
    tick();

    // Clear request together with a write: write lands, then gets cleared.
    drive(1'b1, 3'd6, 8'h5A, 3'd6, 3'd7, 1'b0, 3'd0, 1'b1);
    @(negedge Clk);
    check("clrreq_busy", 32'(ifa.Busy), 32'h0);
    check("clrreq_a_byp", 32'(ifa.RdatA), 32'h5A);
    check("clrreq_b_nobyp", 32'(ifb.RdatA), 32'h77);
    tick();

    for (int k = 0; k < 8; k++) begin
      if (k == 0)
        drive(1'b1, 3'd7, 8'hEE, 3'd6, 3'd0, 1'b1, 3'd3, 1'b1);
      else
        drive(1'b0, 3'd0, 8'h00, (k == 3) ? 3'd7 : 3'd3, 3'(k - 1), 1'b0, 3'd0, 1'b0);
      @(negedge Clk);
      check($sformatf("clr%0d_busy_a", k), 32'(ifa.Busy), 32'h1);
      check($sformatf("clr%0d_busy_b", k), 32'(ifb.Busy), 32'h1);
      if (k == 0) begin
        check("clr0_a_r6", 32'(ifa.RdatA), 32'h5A);
        check("clr0_b_r6", 32'(ifb.RdatA), 32'h5A);
      end else begin
        check($sformatf("clr%0d_a_cleared", k), 32'(ifa.RdatB), 32'h0);
        check($sformatf("clr%0d_b_cleared", k), 32'(ifb.RdatB), 32'h0);
      end
      if (k == 3) begin
        check("clr3_a_r7_old", 32'(ifa.RdatA), 32'h88);
        check("clr3_b_r7_old", 32'(ifb.RdatA), 32'h88);
      end
      if (k == 5) begin
        check("clr5_a_pend3_dropped", 32'(ifa.PendA), 32'h0);
      end
      tick();
    end

    idle_read(3'd0, 3'd0);
    @(negedge Clk);
    check("clr_done_busy_a", 32'(ifa.Busy), 32'h0);
    check("clr_done_busy_b", 32'(ifb.Busy), 32'h0);
    for (int i = 0; i < 8; i++) begin
      idle_read(3'(i), 3'(i));
      #1;
      check($sformatf("post_clr_a_r%0d", i), 32'(ifa.RdatA), 32'h0);
      check($sformatf("post_clr_b_r%0d", i), 32'(ifb.RdatA), 32'h0);
      check($sformatf("post_clr_a_pb%0d", i), 32'(ifa.PendB), 32'h0);
    end
    tick();

    // Reset during a clear.
    drive(1'b1, 3'd5, 8'h55, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 3'd7, 8'h66, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    idle_read(3'd5, 3'd7);
    tick();
    tick();
    tick();
    @(negedge Clk);
    check("midclr_r7_old", 32'(ifa.RdatB), 32'h66);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b0, 3'd0, 1'b1);
    @(negedge Clk);
    check("midrst_busy_a", 32'(ifa.Busy), 32'h0);
    check("midrst_busy_b", 32'(ifb.Busy), 32'h0);
    check("midrst_a_r5", 32'(ifa.RdatA), 32'h0);
    check("midrst_a_r7", 32'(ifa.RdatB), 32'h0);
    check("midrst_b_r7", 32'(ifb.RdatB), 32'h0);
    tick();
    idle_read(3'd0, 3'd0);

    cnt = 0;
    @(negedge Clk);
    while (ifa.Busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge Clk);
    end
    check("reclr_busy_len", 32'(cnt), 32'd8);
    check("reclr_busy_b_end", 32'(ifb.Busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
